// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix-multiply control path:
// default geometry, sequencer state encoding and a width helper.
package matmul_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_MAX_DIM     = 4;
    localparam int DEFAULT_MATRIX_SIZE = DEFAULT_MAX_DIM * DEFAULT_MAX_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Bits needed to index 'count' items; never returns zero so that a
    // degenerate 1-element range still gets a legal 1-bit vector.
    function automatic int width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/skew_lane_gen.sv
// Skewed address generator for one array lane. Lane k starts k steps
// after lane 0, so at step t it fetches element (t-k) of its row of A
// and of its column of B. Purely combinational.
module skew_lane_gen
    import matmul_pkg::*;
#(
    parameter int MAX_DIM = DEFAULT_MAX_DIM,
    parameter int LANE    = 0,
    parameter int CNT_W   = 4,
    parameter int ADDR_W  = 4
) (
    input  logic [CNT_W-1:0]  t_i,
    input  logic [CNT_W-1:0]  n_i,
    output logic              active_o,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o
);

    localparam logic [CNT_W-1:0]  LANE_C = CNT_W'(LANE);
    localparam logic [ADDR_W-1:0] LANE_A = ADDR_W'(LANE);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAX_DIM);

    logic [CNT_W-1:0]  step;
    logic [ADDR_W-1:0] step_a;

    assign step   = t_i - LANE_C;
    assign step_a = ADDR_W'(step);

    // Lanes at or beyond n stay silent even when the skew window would
    // otherwise cover them; that is what zero-pads the unused PEs.
    assign active_o = (LANE_C < n_i) && (t_i >= LANE_C) && (step < n_i);

    // Row-major addressing at the full array stride, independent of n.
    assign addr_a_o = active_o ? (LANE_A * STRIDE + step_a) : '0;
    assign addr_b_o = active_o ? (step_a * STRIDE + LANE_A) : '0;

endmodule

// File: rtl/systolic_feed_sequencer.sv
// Sequences one matrix multiply through the systolic array: clears the
// accumulators, streams skewed operand reads from the A/B banks onto the
// array edges with zero padding, flushes the pipeline and pulses done.
module systolic_feed_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_DIM     = DEFAULT_MAX_DIM,
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    localparam int ADDR_W     = width_for(MATRIX_SIZE),
    localparam int DIM_W      = width_for(MAX_DIM)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [DIM_W-1:0]                dim_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            clear_o,
    output logic [MAX_DIM-1:0]              rd_en_a_o,
    output logic [MAX_DIM*ADDR_W-1:0]       rd_addr_a_o,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]   rd_data_a_i,
    output logic [MAX_DIM-1:0]              rd_en_b_o,
    output logic [MAX_DIM*ADDR_W-1:0]       rd_addr_b_o,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]   rd_data_b_i,
    output logic [MAX_DIM*DATA_WIDTH-1:0]   left_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]   up_o,
    output logic [MAX_DIM-1:0]              feed_valid_o
);

    // Step counter must hold 2n-2 in FEED and n in FLUSH.
    localparam int               CNT_W   = width_for(2 * MAX_DIM + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIM_W-1:0]   dim_q, dim_d;
    logic [MAX_DIM-1:0] feed_valid_q;

    logic [CNT_W-1:0]   n_w;
    logic [CNT_W-1:0]   last_t_w;

    logic [MAX_DIM-1:0] lane_active;
    logic [ADDR_W-1:0]  lane_addr_a [MAX_DIM];
    logic [ADDR_W-1:0]  lane_addr_b [MAX_DIM];

    assign n_w      = CNT_W'(dim_q) + CNT_ONE;
    assign last_t_w = (n_w << 1) - CNT_TWO;

    for (genvar k = 0; k < MAX_DIM; k++) begin : g_lane
        skew_lane_gen #(
            .MAX_DIM (MAX_DIM),
            .LANE    (k),
            .CNT_W   (CNT_W),
            .ADDR_W  (ADDR_W)
        ) u_lane (
            .t_i      (cnt_q),
            .n_i      (n_w),
            .active_o (lane_active[k]),
            .addr_a_o (lane_addr_a[k]),
            .addr_b_o (lane_addr_b[k])
        );
    end

    // State, counter, latched dimension and one-cycle read-valid pipeline.
    // NOTE: state is written with <= so every flop samples the pre-edge
    // values of its neighbours, mirroring real hardware ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dim_q        <= '0;
            feed_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dim_q        <= dim_d;
            feed_valid_q <= rd_en_a_o;
        end
    end

    // Next-state and counter sequencing; n is captured only on acceptance.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dim_d   = dim_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dim_d   = dim_i;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (cnt_q == last_t_w) begin
                    cnt_d   = '0;
                    state_d = ST_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == n_w) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoded controls, gated read requests and zero-padded edge operands.
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        clear_o     = (state_q == ST_CLEAR);
        done_o      = (state_q == ST_DONE);
        rd_en_a_o   = '0;
        rd_en_b_o   = '0;
        rd_addr_a_o = '0;
        rd_addr_b_o = '0;
        left_o      = '0;
        up_o        = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            if ((state_q == ST_FEED) && lane_active[k]) begin
                rd_en_a_o[k]                   = 1'b1;
                rd_en_b_o[k]                   = 1'b1;
                rd_addr_a_o[k*ADDR_W +: ADDR_W] = lane_addr_a[k];
                rd_addr_b_o[k*ADDR_W +: ADDR_W] = lane_addr_b[k];
            end
            if (feed_valid_q[k]) begin
                left_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_a_i[k*DATA_WIDTH +: DATA_WIDTH];
                up_o[k*DATA_WIDTH +: DATA_WIDTH]   = rd_data_b_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign feed_valid_o = feed_valid_q;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Scoreboard bench for systolic_feed_sequencer: ideal 1-cycle banks, a
// small systolic array model, expected reads/feeds/completions queued by
// the stimulus and checked by an independent negedge monitor.
module tb_systolic_feed_sequencer;

    localparam int DW   = 32;
    localparam int MD   = 4;
    localparam int AW   = 4;
    localparam int DIMW = 2;

    typedef struct packed {
        logic [MD-1:0]    en_a;
        logic [MD*AW-1:0] addr_a;
        logic [MD-1:0]    en_b;
        logic [MD*AW-1:0] addr_b;
    } rd_rec_t;

    typedef struct packed {
        logic [MD-1:0]    mask;
        logic [MD*DW-1:0] left;
        logic [MD*DW-1:0] up;
    } feed_rec_t;

    typedef struct packed {
        logic [31:0]         len;
        logic [MD*MD*DW-1:0] c;
    } done_rec_t;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [DIMW-1:0]     dim_i;
    logic                busy_o, done_o, clear_o;
    logic [MD-1:0]       rd_en_a_o, rd_en_b_o, feed_valid_o;
    logic [MD*AW-1:0]    rd_addr_a_o, rd_addr_b_o;
    logic [MD*DW-1:0]    rd_data_a_i, rd_data_b_i, left_o, up_o;

    logic [DW-1:0] mem_a [MD*MD];
    logic [DW-1:0] mem_b [MD*MD];
    logic [DW-1:0] a_reg [MD][MD];
    logic [DW-1:0] b_reg [MD][MD];
    logic [DW-1:0] acc   [MD][MD];

    rd_rec_t   q_rd   [$];
    feed_rec_t q_feed [$];
    done_rec_t q_done [$];
    int        done_cyc [$];

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;
    int busy_cnt   = 0;
    int cyc        = 0;

    always #5 clk_i = ~clk_i;

    systolic_feed_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .dim_i        (dim_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .clear_o      (clear_o),
        .rd_en_a_o    (rd_en_a_o),
        .rd_addr_a_o  (rd_addr_a_o),
        .rd_data_a_i  (rd_data_a_i),
        .rd_en_b_o    (rd_en_b_o),
        .rd_addr_b_o  (rd_addr_b_o),
        .rd_data_b_i  (rd_data_b_i),
        .left_o       (left_o),
        .up_o         (up_o),
        .feed_valid_o (feed_valid_o)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Ideal banks: data one cycle after the address; disabled lanes return junk.
    always @(posedge clk_i) begin
        for (int k = 0; k < MD; k++) begin
            rd_data_a_i[k*DW +: DW] <= rd_en_a_o[k] ? mem_a[rd_addr_a_o[k*AW +: AW]] : DW'(32'hDEAD_0000 + k);
            rd_data_b_i[k*DW +: DW] <= rd_en_b_o[k] ? mem_b[rd_addr_b_o[k*AW +: AW]] : DW'(32'hBEEF_0000 + k);
        end
    end

    function automatic logic [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return left_o[i*DW +: DW];
        return a_reg[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return up_o[j*DW +: DW];
        return b_reg[i-1][j];
    endfunction

    // Output-stationary systolic array model driven by the DUT edge outputs.
    always @(posedge clk_i) begin
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                if (clear_o) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else begin
                    a_reg[i][j] <= a_in(i, j);
                    b_reg[i][j] <= b_in(i, j);
                    acc[i][j]   <= acc[i][j] + a_in(i, j) * b_in(i, j);
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        rd_rec_t          r;
        feed_rec_t        f;
        done_rec_t        d;
        logic [2*MD*DW-1:0] pad;
        logic [MD*MD*DW-1:0] accv;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (busy_o) busy_cnt++;
                else        busy_cnt = 0;

                if (busy_o && (clear_o || busy_cnt == 1))
                    check("clear_cycle", clear_o, busy_cnt == 1);
                if (!busy_o)
                    check("idle_ctrl", {clear_o, done_o, rd_en_a_o, rd_en_b_o, feed_valid_o}, '0);

                if ((rd_en_a_o | rd_en_b_o) != '0) begin
                    if (q_rd.size() == 0) begin
                        check("rd_unexpected", rd_en_a_o | rd_en_b_o, '0);
                    end else begin
                        r = q_rd.pop_front();
                        check("rd_en_a", rd_en_a_o, r.en_a);
                        check("rd_addr_a", rd_addr_a_o, r.addr_a);
                        check("rd_en_b", rd_en_b_o, r.en_b);
                        check("rd_addr_b", rd_addr_b_o, r.addr_b);
                    end
                end else if (busy_o) begin
                    check("rd_addr_quiet", {rd_addr_a_o, rd_addr_b_o}, '0);
                end

                if (feed_valid_o != '0) begin
                    if (q_feed.size() == 0) begin
                        check("feed_unexpected", feed_valid_o, '0);
                    end else begin
                        f = q_feed.pop_front();
                        check("feed_valid", feed_valid_o, f.mask);
                        check("left", left_o, f.left);
                        check("up", up_o, f.up);
                    end
                end

                if (busy_o) begin
                    pad = '0;
                    for (int k = 0; k < MD; k++) begin
                        if (!feed_valid_o[k]) begin
                            pad[k*DW +: DW]        = left_o[k*DW +: DW];
                            pad[(MD+k)*DW +: DW]   = up_o[k*DW +: DW];
                        end
                    end
                    check("zero_pad", pad, '0);
                end

                if (done_o) begin
                    done_count++;
                    done_cyc.push_back(cyc);
                    if (q_done.size() == 0) begin
                        check("done_unexpected", done_o, 1'b0);
                    end else begin
                        d = q_done.pop_front();
                        for (int i = 0; i < MD; i++)
                            for (int j = 0; j < MD; j++)
                                accv[(i*MD+j)*DW +: DW] = acc[i][j];
                        check("busy_len", busy_cnt, d.len);
                        check("result_c", accv, d.c);
                    end
                end
            end
        end
    end

    function automatic void push_op(input int n, input logic [MD*MD*DW-1:0] c);
        rd_rec_t   r;
        feed_rec_t f;
        done_rec_t d;
        for (int t = 0; t <= 2*n-2; t++) begin
            r = '0;
            f = '0;
            for (int k = 0; k < MD; k++) begin
                if (k < n && t >= k && t - k < n) begin
                    r.en_a[k]            = 1'b1;
                    r.en_b[k]            = 1'b1;
                    r.addr_a[k*AW +: AW] = AW'(k*MD + (t-k));
                    r.addr_b[k*AW +: AW] = AW'((t-k)*MD + k);
                    f.mask[k]            = 1'b1;
                    f.left[k*DW +: DW]   = mem_a[k*MD + (t-k)];
                    f.up[k*DW +: DW]     = mem_b[(t-k)*MD + k];
                end
            end
            q_rd.push_back(r);
            q_feed.push_back(f);
        end
        d.len = 32'(3*n + 2);
        d.c   = c;
        q_done.push_back(d);
    endfunction

    // A = identity, B[i][j] = 16*i+j, so C = B inside the n x n corner.
    function automatic logic [MD*MD*DW-1:0] exp_identity(input int n);
        logic [MD*MD*DW-1:0] c;
        c = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                c[(i*MD+j)*DW +: DW] = DW'(16*i + j);
        return c;
    endfunction

    task automatic load_identity_ramp();
        for (int a = 0; a < MD*MD; a++) begin
            mem_a[a] = ((a / MD) == (a % MD)) ? 32'd1 : 32'd0;
            mem_b[a] = DW'(16*(a / MD) + (a % MD));
        end
    endtask

    task automatic load_junk();
        for (int a = 0; a < MD*MD; a++) begin
            mem_a[a] = DW'(32'h900 + a);
            mem_b[a] = DW'(32'hA00 + a);
        end
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input int dim);
        start_i = 1'b1;
        dim_i   = DIMW'(dim);
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        if (done_count < target) check("done_timeout", done_count, target);
    endtask

    initial begin
        logic [MD*MD*DW-1:0] c2;
        int base;
        rst_i   = 1'b1;
        start_i = 1'b0;
        dim_i   = '0;
        load_identity_ramp();
        idle_cycles(3);
        check("reset_outputs", {busy_o, done_o, clear_o, rd_en_a_o, rd_en_b_o, rd_addr_a_o,
                                rd_addr_b_o, feed_valid_o, left_o, up_o}, '0);
        rst_i = 1'b0;
        idle_cycles(2);
        check("idle_after_reset", {busy_o, feed_valid_o, left_o, up_o}, '0);

        // n = 4, identity A, ramp B.
        push_op(4, exp_identity(4));
        start_op(3);
        wait_done(1, 40);
        idle_cycles(2);

        // n = 2, lanes 2/3 must stay disabled and padded.
        load_junk();
        mem_a[0] = 1; mem_a[1] = 2; mem_a[4] = 3; mem_a[5] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[4] = 7; mem_b[5] = 8;
        c2 = '0;
        c2[0*DW +: DW] = 19; c2[1*DW +: DW] = 22;
        c2[4*DW +: DW] = 43; c2[5*DW +: DW] = 50;
        push_op(2, c2);
        start_op(1);
        wait_done(2, 40);
        idle_cycles(2);

        // n = 1, single FEED cycle.
        begin
            logic [MD*MD*DW-1:0] c1;
            load_junk();
            mem_a[0] = 7;
            mem_b[0] = 6;
            c1 = '0;
            c1[0 +: DW] = 42;
            push_op(1, c1);
            start_op(0);
            wait_done(3, 40);
            idle_cycles(2);
        end

        // Held start with n = 3: two back-to-back operations; dim_i wiggled mid-run.
        load_identity_ramp();
        base = done_count;
        push_op(3, exp_identity(3));
        push_op(3, exp_identity(3));
        start_i = 1'b1;
        dim_i   = 2'd2;
        idle_cycles(4);
        dim_i = 2'd0;
        idle_cycles(3);
        dim_i = 2'd2;
        wait_done(base + 1, 40);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        wait_done(base + 2, 40);
        if (done_cyc.size() >= 2)
            check("b2b_gap", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 12);
        idle_cycles(2);

        // Reset during FEED t = 3 with n = 4, then a clean restart.
        base = done_count;
        push_op(4, exp_identity(4));
        start_op(3);
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mid_reset_outputs", {busy_o, done_o, clear_o, rd_en_a_o, rd_en_b_o, rd_addr_a_o,
                                    rd_addr_b_o, feed_valid_o, left_o, up_o}, '0);
        rst_i = 1'b0;
        q_rd.delete();
        q_feed.delete();
        q_done.delete();
        idle_cycles(3);
        check("no_done_after_reset", done_count, base);
        push_op(4, exp_identity(4));
        start_op(3);
        wait_done(base + 1, 40);
        idle_cycles(2);

        // Start pulses during CLEAR, FLUSH and DONE are ignored (n = 2).
        load_junk();
        mem_a[0] = 1; mem_a[1] = 2; mem_a[4] = 3; mem_a[5] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[4] = 7; mem_b[5] = 8;
        base = done_count;
        push_op(2, c2);
        start_op(1);
        start_i = 1'b1;                 // CLEAR
        idle_cycles(1);
        start_i = 1'b0;
        idle_cycles(3);
        start_i = 1'b1;                 // FLUSH f = 0
        idle_cycles(1);
        start_i = 1'b0;
        idle_cycles(2);
        start_i = 1'b1;                 // DONE
        idle_cycles(1);
        start_i = 1'b0;
        idle_cycles(10);
        check("single_done", done_count, base + 1);
        check("idle_at_end", busy_o, 1'b0);

        check("queues_empty", {q_rd.size(), q_feed.size(), q_done.size()}, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
